// File: rtl/mmio_responder_if.sv
// rtl/mmio_responder_if.sv - core data-port bus between the CPU and the MMIO responder
interface mmio_responder_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - data RAM, button, frame timer and sprite registers behind the core data port
module mmio_responder #(
    parameter int RAM_WORDS = 64,
    parameter int TICK_DIV  = 833333,
    parameter int NBTN      = 5
) (
    input  logic              clk,
    input  logic              reset,
    mmio_responder_if.slave   bus,
    input  logic [NBTN-1:0]   buttons,
    output logic [9:0]        player_x,
    output logic [9:0]        player_y,
    output logic              tick_irq
);
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int DW = $clog2(TICK_DIV);

    logic [31:0]     ram_q [RAM_WORDS];
    logic [NBTN-1:0] s1_q, s1_d, s2_q, s2_d, p_q, p_d, edge_q, edge_d;
    logic [31:0]     frame_q, frame_d;
    logic            flag_q, flag_d;
    logic [DW-1:0]   div_q, div_d;
    logic [9:0]      x_q, x_d, y_q, y_d;

    logic [31:0]     word_adr;
    logic [AW-1:0]   ram_idx;
    logic            ram_hit, hit_state, hit_edge, hit_frame, hit_flag, hit_xy;
    logic            tick;
    logic            unused_bits;

    assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData};

    always_comb begin
        word_adr  = {bus.DataAdr[31:2], 2'b00};
        ram_idx   = bus.DataAdr[2 +: AW];
        ram_hit   = (bus.DataAdr[31:8] == 24'd0) && ({1'b0, bus.DataAdr[7:2]} < 7'(RAM_WORDS));
        hit_state = (word_adr == 32'h0000_1000);
        hit_edge  = (word_adr == 32'h0000_1004);
        hit_frame = (word_adr == 32'h0000_1008);
        hit_flag  = (word_adr == 32'h0000_100C);
        hit_xy    = (word_adr == 32'h0000_1010);
    end

    // Unmapped space, including RAM indices past RAM_WORDS, always reads as zero.
    always_comb begin
        bus.ReadData = 32'd0;
        if (ram_hit)        bus.ReadData = ram_q[ram_idx];
        else if (hit_state) bus.ReadData[NBTN-1:0] = s2_q;
        else if (hit_edge)  bus.ReadData[NBTN-1:0] = edge_q;
        else if (hit_frame) bus.ReadData = frame_q;
        else if (hit_flag)  bus.ReadData[0] = flag_q;
        else if (hit_xy)    bus.ReadData = {6'd0, y_q, 6'd0, x_q};
    end

    always_comb begin
        s1_d   = buttons;
        s2_d   = s1_q;
        p_d    = s2_q;
        edge_d = edge_q;
        if (bus.MemWrite && hit_edge) edge_d = edge_d & ~bus.WriteData[NBTN-1:0];
        edge_d = edge_d | (s2_q & ~p_q);

        tick    = (div_q == DW'(TICK_DIV - 1));
        div_d   = tick ? '0 : div_q + 1'b1;
        frame_d = tick ? frame_q + 32'd1 : frame_q;
        if (bus.MemWrite && hit_frame) frame_d = bus.WriteData;
        flag_d  = flag_q;
        if (bus.MemWrite && hit_flag && bus.WriteData[0]) flag_d = 1'b0;
        if (tick) flag_d = 1'b1;

        x_d = x_q;
        y_d = y_q;
        if (bus.MemWrite && hit_xy) begin
            x_d = bus.WriteData[9:0];
            y_d = bus.WriteData[25:16];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            p_q     <= '0;
            edge_q  <= '0;
            frame_q <= '0;
            flag_q  <= 1'b0;
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            p_q     <= p_d;
            edge_q  <= edge_d;
            frame_q <= frame_d;
            flag_q  <= flag_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // RAM has no reset; stores are still blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && ram_hit) ram_q[ram_idx] <= bus.WriteData;
    end

    assign player_x = x_q;
    assign player_y = y_q;
    assign tick_irq = flag_q;
endmodule
